// File: rtl/id_opfetch_pkg.sv
// Shared widths, pipeline constants and ID/EX latch types for the operand-fetch stage.
package id_opfetch_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 8;
    localparam int CNT_W  = 32;

    localparam logic [DATA_W-1:0] ZeroWord     = '0;
    localparam logic [ADDR_W-1:0] NOPRegAddr   = '0;
    localparam logic [OP_W-1:0]   EXE_NOP_OP   = 8'h00;
    localparam logic              ReadEnable   = 1'b1;
    localparam logic              ReadDisable  = 1'b0;
    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;

    // What the ID/EX latch does on the next clock edge (reset is handled separately).
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_BUBBLE = 2'd3
    } latch_act_e;

    // Contents of the ID/EX latch.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [OP_W-1:0]   aluop;
    } idex_t;

    // An empty pipeline slot: no write-back, NOP opcode, zero operands.
    function automatic idex_t idex_bubble();
        idex_t b;
        b.valid = 1'b0;
        b.reg1  = ZeroWord;
        b.reg2  = ZeroWord;
        b.wd    = NOPRegAddr;
        b.wreg  = WriteDisable;
        b.aluop = EXE_NOP_OP;
        return b;
    endfunction

endpackage

// File: rtl/id_opfetch_if.sv
// Bundle of decode inputs, register-file read ports, forwarding sources and ID/EX outputs.
interface id_opfetch_if;
    import id_opfetch_pkg::*;

    logic              inst_valid_i;
    logic [ADDR_W-1:0] rs_addr_i;
    logic [ADDR_W-1:0] rt_addr_i;
    logic              rs_use_i;
    logic              rt_use_i;
    logic              imm_sel_i;
    logic [DATA_W-1:0] imm_i;
    logic [ADDR_W-1:0] wd_i;
    logic              wreg_i;
    logic [OP_W-1:0]   aluop_i;

    logic [ADDR_W-1:0] reg1_addr_o;
    logic [ADDR_W-1:0] reg2_addr_o;
    logic              reg1_read_o;
    logic              reg2_read_o;
    logic [DATA_W-1:0] reg1_data_i;
    logic [DATA_W-1:0] reg2_data_i;

    logic [ADDR_W-1:0] ex_wd_i;
    logic              ex_wreg_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              ex_is_load_i;
    logic [ADDR_W-1:0] mem_wd_i;
    logic              mem_wreg_i;
    logic [DATA_W-1:0] mem_wdata_i;

    logic              stall_i;
    logic              flush_i;
    logic              stallreq_o;

    logic              ex_valid_o;
    logic [DATA_W-1:0] ex_reg1_o;
    logic [DATA_W-1:0] ex_reg2_o;
    logic [ADDR_W-1:0] ex_wd_o;
    logic              ex_wreg_o;
    logic [OP_W-1:0]   ex_aluop_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output inst_valid_i, rs_addr_i, rt_addr_i, rs_use_i, rt_use_i, imm_sel_i, imm_i,
               wd_i, wreg_i, aluop_i, reg1_data_i, reg2_data_i,
               ex_wd_i, ex_wreg_i, ex_wdata_i, ex_is_load_i,
               mem_wd_i, mem_wreg_i, mem_wdata_i, stall_i, flush_i,
        input  reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o, stallreq_o,
               ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o, stall_cnt_o
    );

    modport slave (
        input  inst_valid_i, rs_addr_i, rt_addr_i, rs_use_i, rt_use_i, imm_sel_i, imm_i,
               wd_i, wreg_i, aluop_i, reg1_data_i, reg2_data_i,
               ex_wd_i, ex_wreg_i, ex_wdata_i, ex_is_load_i,
               mem_wd_i, mem_wreg_i, mem_wdata_i, stall_i, flush_i,
        output reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o, stallreq_o,
               ex_valid_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_aluop_o, stall_cnt_o
    );

endinterface

// File: rtl/id_opfetch_opnd_fwd.sv
// Resolves one source operand from the register file, EX/MEM forwarding or the immediate,
// and flags a load-use hazard when the value is still being loaded in EX.
module opnd_fwd
    import id_opfetch_pkg::*;
(
    input  logic              i_read_en,
    input  logic              i_imm_sel,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic [ADDR_W-1:0] i_ex_wd,
    input  logic              i_ex_wreg,
    input  logic [DATA_W-1:0] i_ex_wdata,
    input  logic              i_ex_is_load,
    input  logic [ADDR_W-1:0] i_mem_wd,
    input  logic              i_mem_wreg,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] o_data,
    output logic              o_load_hazard
);

    logic w_addr_nz;
    logic w_ex_hit;
    logic w_mem_hit;

    assign w_addr_nz = (i_addr != NOPRegAddr);
    assign w_ex_hit  = i_ex_wreg & (i_ex_wd == i_addr);
    assign w_mem_hit = i_mem_wreg & (i_mem_wd == i_addr);

    // A load in EX has no data yet, so a matching read must wait one cycle.
    assign o_load_hazard = i_read_en & w_addr_nz & w_ex_hit & i_ex_is_load;

    // Pick the youngest valid producer; r0 is hard-wired to zero.
    always_comb begin
        o_data = ZeroWord;
        if (!i_read_en) begin
            o_data = i_imm_sel ? i_imm : ZeroWord;
        end else if (!w_addr_nz) begin
            o_data = ZeroWord;
        end else if (w_ex_hit && !i_ex_is_load) begin
            o_data = i_ex_wdata;
        end else if (w_mem_hit) begin
            o_data = i_mem_wdata;
        end else begin
            o_data = i_rf_data;
        end
    end

endmodule

// File: rtl/id_opfetch.sv
// Operand fetch and ID/EX latch: drives register-file reads, forwards from EX/MEM,
// requests a bubble on load-use and counts the bubbles it inserts.
module id_opfetch
    import id_opfetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    id_opfetch_if.slave bus
);

    logic              w_read1_en;
    logic              w_read2_en;
    logic [DATA_W-1:0] w_opnd1;
    logic [DATA_W-1:0] w_opnd2;
    logic              w_hz1;
    logic              w_hz2;
    logic              w_stallreq;
    latch_act_e        w_act;
    idex_t             w_idex_load;
    idex_t             r_idex;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_read1_en = bus.inst_valid_i & bus.rs_use_i;
    assign w_read2_en = bus.inst_valid_i & bus.rt_use_i & ~bus.imm_sel_i;

    assign bus.reg1_addr_o = bus.rs_addr_i;
    assign bus.reg2_addr_o = bus.rt_addr_i;
    assign bus.reg1_read_o = w_read1_en;
    assign bus.reg2_read_o = w_read2_en;

    opnd_fwd u_fwd1 (
        .i_read_en     (w_read1_en),
        .i_imm_sel     (1'b0),
        .i_imm         (ZeroWord),
        .i_addr        (bus.rs_addr_i),
        .i_rf_data     (bus.reg1_data_i),
        .i_ex_wd       (bus.ex_wd_i),
        .i_ex_wreg     (bus.ex_wreg_i),
        .i_ex_wdata    (bus.ex_wdata_i),
        .i_ex_is_load  (bus.ex_is_load_i),
        .i_mem_wd      (bus.mem_wd_i),
        .i_mem_wreg    (bus.mem_wreg_i),
        .i_mem_wdata   (bus.mem_wdata_i),
        .o_data        (w_opnd1),
        .o_load_hazard (w_hz1)
    );

    opnd_fwd u_fwd2 (
        .i_read_en     (w_read2_en),
        .i_imm_sel     (bus.imm_sel_i),
        .i_imm         (bus.imm_i),
        .i_addr        (bus.rt_addr_i),
        .i_rf_data     (bus.reg2_data_i),
        .i_ex_wd       (bus.ex_wd_i),
        .i_ex_wreg     (bus.ex_wreg_i),
        .i_ex_wdata    (bus.ex_wdata_i),
        .i_ex_is_load  (bus.ex_is_load_i),
        .i_mem_wd      (bus.mem_wd_i),
        .i_mem_wreg    (bus.mem_wreg_i),
        .i_mem_wdata   (bus.mem_wdata_i),
        .o_data        (w_opnd2),
        .o_load_hazard (w_hz2)
    );

    assign w_stallreq     = w_hz1 | w_hz2;
    assign bus.stallreq_o = w_stallreq;

    assign w_idex_load = '{valid: bus.inst_valid_i,
                           reg1:  w_opnd1,
                           reg2:  w_opnd2,
                           wd:    bus.wd_i,
                           wreg:  bus.wreg_i,
                           aluop: bus.aluop_i};

    // Flush beats a downstream hold, which in turn beats our own load-use bubble.
    always_comb begin
        w_act = ACT_LOAD;
        if (bus.flush_i) begin
            w_act = ACT_FLUSH;
        end else if (bus.stall_i) begin
            w_act = ACT_HOLD;
        end else if (w_stallreq) begin
            w_act = ACT_BUBBLE;
        end
    end

    // ID/EX latch update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex <= idex_bubble();
        end else begin
            case (w_act)
                ACT_FLUSH,
                ACT_BUBBLE: r_idex <= idex_bubble();
                ACT_HOLD:   r_idex <= r_idex;
                default:    r_idex <= w_idex_load;
            endcase
        end
    end

    // Saturating count of bubbles caused only by load-use hazards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((w_act == ACT_BUBBLE) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.ex_valid_o  = r_idex.valid;
    assign bus.ex_reg1_o   = r_idex.reg1;
    assign bus.ex_reg2_o   = r_idex.reg2;
    assign bus.ex_wd_o     = r_idex.wd;
    assign bus.ex_wreg_o   = r_idex.wreg;
    assign bus.ex_aluop_o  = r_idex.aluop;
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule
